register_file_mp: RTL and testbench

Parametrised multi-cycle-CPU register file with 2^ADDR_W registers of W bits, two combinational read ports and one synchronous write port. The top register doubles as the program counter, with its own increment-load path. Adds optional hard-wired zero register, optional write-to-read bypass, and a per-register busy scoreboard for the multi-cycle controller. Sits between the decode/control FSM and the ALU operand muxes.

---
 rtl/register_file_mp.sv | 118 +++++++++++
 tb/tb_register_file_mp.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file for a multi-cycle CPU: two combinational read ports, one write port,
// top register doubling as the PC, optional zero register, write-to-read bypass and busy scoreboard.
module register_file_mp #(
   parameter int W        = 8,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [W-1:0]      WD3,
   input  logic              enable,
   input  logic [W-1:0]      pc_in,
   input  logic              pc_we,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic              rsv,
   output logic [W-1:0]      RD1,
   output logic [W-1:0]      RD2,
   output logic [W-1:0]      PC,
   output logic              busy1,
   output logic              busy2
);
   localparam int N = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR   = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

   logic [W-1:0] regs_q [N];
   logic [W-1:0] regs_d [N];
   logic [N-1:0] busy_q;
   logic [N-1:0] busy_d;

   // Next state: PC load first so an architectural write to R[N-1] overrides it; reserve beats clear.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (pc_we) begin
         regs_d[N-1] = pc_in;
      end else begin
         regs_d[N-1] = regs_q[N-1];
      end
      if (enable) begin
         regs_d[A3] = WD3;
         busy_d[A3] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (rsv) begin
         busy_d[rsv_addr] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      if (ZERO_REG) begin
         regs_d[0] = {W{1'b0}};
         busy_d[0] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            regs_q[i] <= {W{1'b0}};
         end
         busy_q <= {N{1'b0}};
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Read port 1: bypass suppressed during reset so reads are 0 immediately.
   always_comb begin
      RD1   = regs_q[A1];
      busy1 = busy_q[A1];
      if (BYPASS && !rst && enable && (A3 == A1)) begin
         RD1   = WD3;
         busy1 = 1'b0;
      end else if (BYPASS && !rst && pc_we && (A1 == PC_ADDR)) begin
         RD1 = pc_in;
      end else begin
         busy1 = busy1;
      end
      if (ZERO_REG && (A1 == ZERO_ADDR)) begin
         RD1   = {W{1'b0}};
         busy1 = 1'b0;
      end else begin
         busy1 = busy1;
      end
   end

   // Read port 2: same rules as port 1.
   always_comb begin
      RD2   = regs_q[A2];
      busy2 = busy_q[A2];
      if (BYPASS && !rst && enable && (A3 == A2)) begin
         RD2   = WD3;
         busy2 = 1'b0;
      end else if (BYPASS && !rst && pc_we && (A2 == PC_ADDR)) begin
         RD2 = pc_in;
      end else begin
         busy2 = busy2;
      end
      if (ZERO_REG && (A2 == ZERO_ADDR)) begin
         RD2   = {W{1'b0}};
         busy2 = 1'b0;
      end else begin
         busy2 = busy2;
      end
   end

   assign PC = regs_q[N-1];

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: instance 0 is plain (BYPASS=0, ZERO_REG=0), instance 1 has BYPASS=1, ZERO_REG=1;
// both share stimulus and are compared against an array-based reference model.
module tb_register_file_mp;
   logic       clock = 1'b0;
   logic       rst;
   logic [2:0] A1, A2, A3, rsv_addr;
   logic [7:0] WD3, pc_in;
   logic       enable, pc_we, rsv;
   logic [7:0] rd1_o [2];
   logic [7:0] rd2_o [2];
   logic [7:0] pc_o  [2];
   logic       busy1_o [2];
   logic       busy2_o [2];

   logic [7:0] m_reg  [2][8];
   logic [7:0] m_busy [2];
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   register_file_mp #(.W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_plain (
      .clock(clock), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .enable(enable),
      .pc_in(pc_in), .pc_we(pc_we), .rsv_addr(rsv_addr), .rsv(rsv),
      .RD1(rd1_o[0]), .RD2(rd2_o[0]), .PC(pc_o[0]), .busy1(busy1_o[0]), .busy2(busy2_o[0]));

   register_file_mp #(.W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_byp (
      .clock(clock), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .enable(enable),
      .pc_in(pc_in), .pc_we(pc_we), .rsv_addr(rsv_addr), .rsv(rsv),
      .RD1(rd1_o[1]), .RD2(rd2_o[1]), .PC(pc_o[1]), .busy1(busy1_o[1]), .busy2(busy2_o[1]));

   // Reference read value: instance 1 has zero register and bypass.
   function automatic logic [7:0] exp_rd(input int k, input logic [2:0] a);
      if (k == 1 && a == 3'd0) return 8'h00;
      if (k == 1 && !rst) begin
         if (enable && A3 == a) return WD3;
         if (pc_we && a == 3'd7) return pc_in;
      end
      return m_reg[k][a];
   endfunction

   function automatic logic exp_busy(input int k, input logic [2:0] a);
      if (k == 1 && a == 3'd0) return 1'b0;
      if (k == 1 && !rst && enable && A3 == a) return 1'b0;
      return m_busy[k][a];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 8; r++) m_reg[k][r] = 8'h00;
         m_busy[k] = 8'h00;
      end
   endtask

   // Apply the architectural rules for the coming edge, then advance one clock.
   task automatic step();
      logic [7:0] nb;
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            nb = m_busy[k];
            if (enable) nb[A3] = 1'b0;
            if (rsv) nb[rsv_addr] = 1'b1;
            if (pc_we) m_reg[k][7] = pc_in;
            if (enable) m_reg[k][A3] = WD3;
            if (k == 1) begin
               m_reg[1][0] = 8'h00;
               nb[0] = 1'b0;
            end
            m_busy[k] = nb;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      enable = 1'b0; pc_we = 1'b0; rsv = 1'b0;
      A3 = 3'd0; WD3 = 8'h00; pc_in = 8'h00; rsv_addr = 3'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_clear();
      enable = 1'b1; pc_we = 1'b1; rsv = 1'b1; A3 = 3'd7; WD3 = 8'hEE; pc_in = 8'hDD; rsv_addr = 3'd7;
      step();
      for (int a = 0; a < 8; a++) begin
         A1 = 3'(a); A2 = 3'(7 - a);
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1_o[k] !== 8'h00 || rd2_o[k] !== 8'h00 || pc_o[k] !== 8'h00 ||
                busy1_o[k] !== 1'b0 || busy2_o[k] !== 1'b0) begin
               errors++;
               $display("FAIL reset inst%0d a=%0d: rd1=%h rd2=%h pc=%h b1=%b b2=%b, required all 0",
                        k, a, rd1_o[k], rd2_o[k], pc_o[k], busy1_o[k], busy2_o[k]);
            end
         end
      end
      idle();
      @(negedge clock);
      rst = 1'b0;
   endtask

   task automatic test_write_readback();
      enable = 1'b1; A3 = 3'd3; WD3 = 8'hA5; A1 = 3'd3; A2 = 3'd3;
      #1;
      checks++;
      if (rd1_o[0] !== 8'h00) begin
         errors++; $display("FAIL wr_before_edge inst0: got %h required 00", rd1_o[0]);
      end
      checks++;
      if (rd1_o[1] !== 8'hA5) begin
         errors++; $display("FAIL wr_bypass inst1: got %h required a5", rd1_o[1]);
      end
      step();
      idle();
      for (int a = 0; a < 8; a++) begin
         A1 = 3'(a); A2 = 3'(a);
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1_o[k] !== ((a == 3) ? 8'hA5 : 8'h00) || rd2_o[k] !== rd1_o[k]) begin
               errors++;
               $display("FAIL readback inst%0d a=%0d: rd1=%h rd2=%h required %h",
                        k, a, rd1_o[k], rd2_o[k], (a == 3) ? 8'hA5 : 8'h00);
            end
         end
      end
   endtask

   task automatic test_bypass_zero();
      enable = 1'b1; A3 = 3'd5; A1 = 3'd5; WD3 = 8'h3C;
      #1;
      checks++;
      if (rd1_o[1] !== 8'h3C) begin
         errors++; $display("FAIL bypass_same_cycle: got %h required 3c", rd1_o[1]);
      end
      step();
      A3 = 3'd0; WD3 = 8'hFF; A1 = 3'd0;
      #1;
      checks++;
      if (rd1_o[1] !== 8'h00) begin
         errors++; $display("FAIL zero_no_bypass: got %h required 00", rd1_o[1]);
      end
      step();
      idle();
      #1;
      checks++;
      if (rd1_o[1] !== 8'h00 || rd1_o[0] !== 8'hFF) begin
         errors++; $display("FAIL zero_reg: inst1=%h required 00, inst0=%h required ff", rd1_o[1], rd1_o[0]);
      end
   endtask

   task automatic test_pc_priority();
      pc_we = 1'b1; pc_in = 8'h11; enable = 1'b1; A3 = 3'd7; WD3 = 8'h40; A2 = 3'd7;
      #1;
      checks++;
      if (rd2_o[1] !== 8'h40 || pc_o[1] !== 8'h00) begin
         errors++; $display("FAIL pc_bypass: rd2=%h required 40, pc=%h required 00", rd2_o[1], pc_o[1]);
      end
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (pc_o[k] !== 8'h40) begin
            errors++; $display("FAIL pc_wd3_wins inst%0d: got %h required 40", k, pc_o[k]);
         end
      end
      enable = 1'b0; pc_in = 8'h41;
      step();
      idle();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (pc_o[k] !== 8'h41) begin
            errors++; $display("FAIL pc_load inst%0d: got %h required 41", k, pc_o[k]);
         end
      end
   endtask

   task automatic test_scoreboard();
      rsv = 1'b1; rsv_addr = 3'd2; A1 = 3'd2;
      step();
      rsv = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (busy1_o[k] !== 1'b1) begin
            errors++; $display("FAIL sb_reserve inst%0d: got %b required 1", k, busy1_o[k]);
         end
      end
      rsv = 1'b1; enable = 1'b1; A3 = 3'd2; WD3 = 8'h22;
      step();
      rsv = 1'b0; enable = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (busy1_o[k] !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins inst%0d: got %b required 1", k, busy1_o[k]);
         end
      end
      enable = 1'b1; WD3 = 8'h23;
      #1;
      checks++;
      if (busy1_o[0] !== 1'b1 || busy1_o[1] !== 1'b0) begin
         errors++; $display("FAIL sb_arriving: inst0=%b required 1, inst1=%b required 0", busy1_o[0], busy1_o[1]);
      end
      step();
      idle();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (busy1_o[k] !== 1'b0 || rd1_o[k] !== 8'h23) begin
            errors++; $display("FAIL sb_cleared inst%0d: busy=%b rd1=%h required 0/23", k, busy1_o[k], rd1_o[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         A1 = 3'($urandom_range(7)); A2 = 3'($urandom_range(7)); A3 = 3'($urandom_range(7));
         WD3 = 8'($urandom); pc_in = 8'($urandom); rsv_addr = 3'($urandom_range(7));
         enable = ($urandom_range(2) == 0); pc_we = ($urandom_range(3) == 0); rsv = ($urandom_range(2) == 0);
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd1_o[k] !== exp_rd(k, A1) || rd2_o[k] !== exp_rd(k, A2) || pc_o[k] !== m_reg[k][7] ||
                busy1_o[k] !== exp_busy(k, A1) || busy2_o[k] !== exp_busy(k, A2)) begin
               errors++;
               $display("FAIL random inst%0d cyc%0d: rd1=%h/%h rd2=%h/%h pc=%h/%h b1=%b/%b b2=%b/%b (got/required)",
                        k, c, rd1_o[k], exp_rd(k, A1), rd2_o[k], exp_rd(k, A2), pc_o[k], m_reg[k][7],
                        busy1_o[k], exp_busy(k, A1), busy2_o[k], exp_busy(k, A2));
            end
         end
         step();
      end
      idle();
   endtask

   task automatic test_async_reset();
      enable = 1'b1; A3 = 3'd4; WD3 = 8'h77; rsv = 1'b1; rsv_addr = 3'd4;
      step();
      idle();
      A1 = 3'd4;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rd1_o[k] !== 8'h77 || busy1_o[k] !== 1'b1) begin
            errors++; $display("FAIL ar_setup inst%0d: rd1=%h busy=%b required 77/1", k, rd1_o[k], busy1_o[k]);
         end
      end
      enable = 1'b1; pc_we = 1'b1; rsv = 1'b1; WD3 = 8'h55; pc_in = 8'h66;
      #1;
      rst = 1'b1;
      model_clear();
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rd1_o[k] !== 8'h00 || busy1_o[k] !== 1'b0 || pc_o[k] !== 8'h00) begin
            errors++; $display("FAIL ar_immediate inst%0d: rd1=%h busy=%b pc=%h required 0", k, rd1_o[k], busy1_o[k], pc_o[k]);
         end
      end
      step();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rd1_o[k] !== 8'h00 || busy1_o[k] !== 1'b0 || pc_o[k] !== 8'h00) begin
            errors++; $display("FAIL ar_held inst%0d: rd1=%h busy=%b pc=%h required 0", k, rd1_o[k], busy1_o[k], pc_o[k]);
         end
      end
      @(negedge clock);
      rst = 1'b0;
      idle();
      enable = 1'b1; A3 = 3'd4; WD3 = 8'h12;
      step();
      idle();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rd1_o[k] !== 8'h12 || pc_o[k] !== 8'h00) begin
            errors++; $display("FAIL ar_first_edge inst%0d: rd1=%h pc=%h required 12/00", k, rd1_o[k], pc_o[k]);
         end
      end
   endtask

   initial begin
      A1 = 3'd0; A2 = 3'd0;
      idle();
      test_reset();
      test_write_readback();
      test_bypass_zero();
      test_pc_priority();
      test_scoreboard();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
